// File: rtl/codec_buffer_pkg.sv
// Shared types, width helpers and the elaboration-time width checks for the
// codec DWC ring buffer.
package codec_buffer_pkg;

  localparam int unsigned cBNUM_W_MIN = 1;
  localparam int unsigned cBNUM_W_MAX = 4;
  // Count and length both need one bit above their pointer/address so the
  // completely-full value (N banks, 2**pWADDR_W strobes) is representable.
  localparam int unsigned cFULL_XTRA_W = 1;

  // Per-cycle effect of the accepted close/release pair on the bank count.
  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_op_e;

  function automatic int unsigned bank_num(input int unsigned bnum_w);
    return 1 << bnum_w;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned bnum_w);
    return bnum_w + cFULL_XTRA_W;
  endfunction

  function automatic int unsigned len_width(input int unsigned waddr_w);
    return waddr_w + cFULL_XTRA_W;
  endfunction

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  // Both sides must address the same number of bits per bank.
  function automatic bit dwc_ok(input int unsigned waddr_w, input int unsigned wdat_w,
                                input int unsigned raddr_w, input int unsigned rdat_w);
    return is_pow2(wdat_w) && is_pow2(rdat_w) &&
           ((waddr_w + $clog2(wdat_w)) == (raddr_w + $clog2(rdat_w)));
  endfunction

endpackage

// File: rtl/codec_buffer_dwc_ring_if.sv
// Write/read side bus of the codec DWC ring buffer.
interface codec_buffer_dwc_ring_if #(
  parameter int pWADDR_W = 8,
  parameter int pWDAT_W  = 8,
  parameter int pRADDR_W = 8,
  parameter int pRDAT_W  = 8,
  parameter int pTAG_W   = 8,
  parameter int pBNUM_W  = 2
);
  logic                iwrite;
  logic                iwfull;
  logic [pWADDR_W-1:0] iwaddr;
  logic [pWDAT_W-1:0]  iwdat;
  logic [pTAG_W-1:0]   iwtag;
  logic                irempty;
  logic [pRADDR_W-1:0] iraddr;
  logic [pRDAT_W-1:0]  ordat;
  logic [pTAG_W-1:0]   ortag;
  logic [pWADDR_W:0]   orlen;
  logic [pBNUM_W:0]    ocount;
  logic                oempty;
  logic                oemptya;
  logic                ofull;
  logic                ofulla;
  logic                oovf;
  logic                oudf;

  modport master (
    output iwrite, iwfull, iwaddr, iwdat, iwtag, irempty, iraddr,
    input  ordat, ortag, orlen, ocount, oempty, oemptya, ofull, ofulla, oovf, oudf
  );

  modport slave (
    input  iwrite, iwfull, iwaddr, iwdat, iwtag, irempty, iraddr,
    output ordat, ortag, orlen, ocount, oempty, oemptya, ofull, ofulla, oovf, oudf
  );
endinterface

// File: rtl/codec_buffer_ring_ctrl.sv
// Bank rotation: write/read pointers, closed-bank count, close/release
// acceptance, sticky overflow/underflow and synchronous flush.
module codec_buffer_ring_ctrl
  import codec_buffer_pkg::*;
#(
  parameter int pBNUM_W = 2
) (
  input  logic               iclk,
  input  logic               ireset,
  input  logic               clkena,
  input  logic               clr,
  input  logic               wfull,
  input  logic               rempty,
  output logic [pBNUM_W-1:0] wptr,
  output logic [pBNUM_W-1:0] rptr,
  output logic [pBNUM_W:0]   count,
  output logic               wclose,
  output logic               ovf,
  output logic               udf
);
  localparam logic [pBNUM_W:0] cBANKS = (pBNUM_W + 1)'(bank_num(pBNUM_W));

  logic    close_ok;
  logic    release_ok;
  cnt_op_e cnt_op;

  // Acceptance is judged on the count held at the start of the cycle
  always_comb begin
    close_ok   = wfull && (count < cBANKS);
    release_ok = rempty && (count != '0);
    cnt_op     = CNT_HOLD;
    if (close_ok && !release_ok)      cnt_op = CNT_INC;
    else if (release_ok && !close_ok) cnt_op = CNT_DEC;
    wclose     = clkena && !clr && close_ok;
  end

  // Pointer/count/flag state; flush wins over close and release
  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else if (clkena) begin
      if (clr) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
        ovf   <= 1'b0;
        udf   <= 1'b0;
      end else begin
        wptr <= wptr + pBNUM_W'(close_ok);
        rptr <= rptr + pBNUM_W'(release_ok);
        case (cnt_op)
          CNT_INC: count <= count + 1'b1;
          CNT_DEC: count <= count - 1'b1;
          default: count <= count;
        endcase
        if (wfull && !close_ok)    ovf <= 1'b1;
        if (rempty && !release_ok) udf <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/codec_mem_dwc_block.sv
// Simple dual-port memory with data-width conversion. Lines are stored at the
// wider of the two widths; the narrow side selects a little-endian lane.
module codec_mem_dwc_block #(
  parameter int pWADDR_W = 8,
  parameter int pWDAT_W  = 8,
  parameter int pRADDR_W = 8,
  parameter int pRDAT_W  = 8,
  parameter int pPIPE    = 1
) (
  input  logic                iclk,
  input  logic                ireset,
  input  logic                iclkena,
  input  logic                iwrite,
  input  logic [pWADDR_W-1:0] iwaddr,
  input  logic [pWDAT_W-1:0]  iwdat,
  input  logic [pRADDR_W-1:0] iraddr,
  output logic [pRDAT_W-1:0]  ordat
);
  localparam int cLINE_W  = (pWDAT_W > pRDAT_W) ? pWDAT_W : pRDAT_W;
  localparam int cWSEL_W  = $clog2(cLINE_W / pWDAT_W);
  localparam int cRSEL_W  = $clog2(cLINE_W / pRDAT_W);
  localparam int cLINE_AW = pWADDR_W - cWSEL_W;
  localparam int cDEPTH   = 1 << cLINE_AW;

  logic [cLINE_W-1:0]           mem [cDEPTH];
  logic [pRDAT_W-1:0]           rword;
  logic [pPIPE:0][pRDAT_W-1:0]  rstage;

  if (cWSEL_W == 0) begin : g_wline
    // Full-line write
    // NOTE: the storage array has no reset -- RAMs cannot be cleared in one cycle,
    // and non-blocking assignment keeps a same-cycle read returning the old line.
    always_ff @(posedge iclk)
      if (iclkena && iwrite) mem[iwaddr] <= iwdat;
  end else begin : g_wlane
    // Narrow write into one lane of a line; lane 0 sits in the LSBs
    always_ff @(posedge iclk)
      if (iclkena && iwrite)
        mem[iwaddr[pWADDR_W-1:cWSEL_W]][iwaddr[cWSEL_W-1:0]*pWDAT_W +: pWDAT_W] <= iwdat;
  end

  if (cRSEL_W == 0) begin : g_rline
    // Full-line read
    // NOTE: assign a default before any branch so always_comb never infers a latch.
    always_comb begin
      rword = '0;
      rword = mem[iraddr];
    end
  end else begin : g_rlane
    // Narrow read of one lane of a line
    always_comb begin
      rword = '0;
      rword = mem[iraddr[pRADDR_W-1:cRSEL_W]][iraddr[cRSEL_W-1:0]*pRDAT_W +: pRDAT_W];
    end
  end

  // Read register plus pPIPE output stages, all held while the clock enable is low
  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      rstage <= '0;
    end else if (iclkena) begin
      rstage[0] <= rword;
      for (int i = 1; i <= pPIPE; i++) rstage[i] <= rstage[i-1];
    end
  end

  assign ordat = rstage[pPIPE];

endmodule

// File: rtl/codec_buffer_dwc_ring.sv
// N-bank codec ring buffer with width conversion, per-bank tag and captured
// frame length, overflow/underflow detection and occupancy flags.
module codec_buffer_dwc_ring
  import codec_buffer_pkg::*;
#(
  parameter int pWADDR_W = 8,
  parameter int pWDAT_W  = 8,
  parameter int pRADDR_W = 8,
  parameter int pRDAT_W  = 8,
  parameter int pTAG_W   = 8,
  parameter int pBNUM_W  = 2,
  parameter int pPIPE    = 1
) (
  input logic                   iclk,
  input logic                   ireset,
  input logic                   iclkena,
  input logic                   iclr,
  codec_buffer_dwc_ring_if.slave bus
);
  localparam int cBANKS = bank_num(pBNUM_W);
  localparam int cLEN_W = len_width(pWADDR_W);
  localparam int cCNT_W = cnt_width(pBNUM_W);
  localparam logic [cLEN_W-1:0] cLEN_MAX = cLEN_W'(1 << pWADDR_W);
  localparam logic [cCNT_W-1:0] cCNT_N   = cCNT_W'(cBANKS);

  if (!dwc_ok(pWADDR_W, pWDAT_W, pRADDR_W, pRDAT_W)) begin : g_bad_dwc
    $error("codec_buffer_dwc_ring: write and read sides must span the same bits per bank");
  end
  if ((pBNUM_W < cBNUM_W_MIN) || (pBNUM_W > cBNUM_W_MAX)) begin : g_bad_bnum
    $error("codec_buffer_dwc_ring: pBNUM_W must be 1..4");
  end

  logic [pBNUM_W-1:0]              wptr;
  logic [pBNUM_W-1:0]              rptr;
  logic [cCNT_W-1:0]               count;
  logic                            wclose;
  logic                            ovf;
  logic                            udf;
  logic [cLEN_W-1:0]               wcnt;
  logic [cLEN_W-1:0]               wcnt_next;
  logic [cBANKS-1:0][pTAG_W-1:0]   tag_ram;
  logic [cBANKS-1:0][cLEN_W-1:0]   len_ram;

  codec_buffer_ring_ctrl #(.pBNUM_W(pBNUM_W)) u_ctrl (
    .iclk   (iclk),
    .ireset (ireset),
    .clkena (iclkena),
    .clr    (iclr),
    .wfull  (bus.iwfull),
    .rempty (bus.irempty),
    .wptr   (wptr),
    .rptr   (rptr),
    .count  (count),
    .wclose (wclose),
    .ovf    (ovf),
    .udf    (udf)
  );

  // Strobe count including this cycle's write, saturating at one full bank
  always_comb begin
    wcnt_next = wcnt;
    if (bus.iwrite && (wcnt != cLEN_MAX)) wcnt_next = wcnt + 1'b1;
  end

  // Strobe counter restarts on every close attempt, accepted or not
  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset)                   wcnt <= '0;
    else if (iclkena) begin
      if (iclr || bus.iwfull)      wcnt <= '0;
      else                         wcnt <= wcnt_next;
    end
  end

  // Tag and length captured into the bank being closed
  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      tag_ram <= '0;
      len_ram <= '0;
    end else if (wclose) begin
      tag_ram[wptr] <= bus.iwtag;
      len_ram[wptr] <= wcnt_next;
    end
  end

  codec_mem_dwc_block #(
    .pWADDR_W (pBNUM_W + pWADDR_W),
    .pWDAT_W  (pWDAT_W),
    .pRADDR_W (pBNUM_W + pRADDR_W),
    .pRDAT_W  (pRDAT_W),
    .pPIPE    (pPIPE)
  ) u_mem (
    .iclk    (iclk),
    .ireset  (ireset),
    .iclkena (iclkena),
    .iwrite  (bus.iwrite),
    .iwaddr  ({wptr, bus.iwaddr}),
    .iwdat   (bus.iwdat),
    .iraddr  ({rptr, bus.iraddr}),
    .ordat   (bus.ordat)
  );

  assign bus.ortag   = tag_ram[rptr];
  assign bus.orlen   = len_ram[rptr];
  assign bus.ocount  = count;
  assign bus.oempty  = (count < cCNT_N);
  assign bus.oemptya = (count == '0);
  assign bus.ofull   = (count != '0);
  assign bus.ofulla  = (count == cCNT_N);
  assign bus.oovf    = ovf;
  assign bus.oudf    = udf;

endmodule

// File: tb/tb_codec_buffer_dwc_ring.sv
// Self-checking bench for codec_buffer_dwc_ring: directed scenarios followed
// by random traffic, all compared against a byte-level behavioural model.
module tb_codec_buffer_dwc_ring;

  localparam int cWADDR_W = 6;
  localparam int cWDAT_W  = 8;
  localparam int cRADDR_W = 4;
  localparam int cRDAT_W  = 32;
  localparam int cTAG_W   = 8;
  localparam int cBNUM_W  = 2;
  localparam int cN       = 4;
  localparam int cBANK_B  = 64;   // bytes per bank

  logic iclk = 1'b0;
  logic ireset;
  logic iclkena;
  logic iclr;

  codec_buffer_dwc_ring_if #(
    .pWADDR_W(cWADDR_W), .pWDAT_W(cWDAT_W), .pRADDR_W(cRADDR_W),
    .pRDAT_W(cRDAT_W), .pTAG_W(cTAG_W), .pBNUM_W(cBNUM_W)
  ) bus ();

  codec_buffer_dwc_ring #(
    .pWADDR_W(cWADDR_W), .pWDAT_W(cWDAT_W), .pRADDR_W(cRADDR_W),
    .pRDAT_W(cRDAT_W), .pTAG_W(cTAG_W), .pBNUM_W(cBNUM_W), .pPIPE(1)
  ) dut (
    .iclk    (iclk),
    .ireset  (ireset),
    .iclkena (iclkena),
    .iclr    (iclr),
    .bus     (bus)
  );

  always #5 iclk = ~iclk;

  int total = 0;
  int bad   = 0;

  // Behavioural model: byte image of all banks with known-flags, per-bank
  // tag/length, head bank and number of closed frames.
  logic [7:0]  mm [cN*cBANK_B];
  bit          mk [cN*cBANK_B];
  logic [7:0]  tag_m [cN];
  int          len_m [cN];
  int          rp, cnt, wcnt;
  bit          ovf, udf;
  logic [31:0] p1, p2;
  bit          p1k, p2k;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    rp = 0; cnt = 0; wcnt = 0; ovf = 0; udf = 0;
    for (int b = 0; b < cN; b++) begin tag_m[b] = '0; len_m[b] = 0; end
    p1 = '0; p2 = '0; p1k = 1; p2k = 1;
  endtask

  task automatic idle();
    bus.iwrite = 0; bus.iwfull = 0; bus.irempty = 0; iclr = 0;
  endtask

  task automatic check_outputs();
    check("ocount",  32'(bus.ocount),  32'(cnt));
    check("oempty",  32'(bus.oempty),  32'(cnt < cN));
    check("oemptya", 32'(bus.oemptya), 32'(cnt == 0));
    check("ofull",   32'(bus.ofull),   32'(cnt > 0));
    check("ofulla",  32'(bus.ofulla),  32'(cnt == cN));
    check("ortag",   32'(bus.ortag),   32'(tag_m[rp]));
    check("orlen",   32'(bus.orlen),   32'(len_m[rp]));
    check("oovf",    32'(bus.oovf),    32'(ovf));
    check("oudf",    32'(bus.oudf),    32'(udf));
    if (p2k) check("ordat", bus.ordat, p2);
  endtask

  // Apply the current inputs to the model, clock once, compare.
  task automatic step();
    int wb, idx, nl;
    logic [31:0] nv;
    bit nk, cok, rok;
    if (iclkena) begin
      wb = (rp + cnt) % cN;
      nv = '0; nk = 1;
      for (int k = 0; k < 4; k++) begin
        idx = rp * cBANK_B + int'(bus.iraddr) * 4 + k;
        nv[k*8 +: 8] = mm[idx];
        if (!mk[idx]) nk = 0;
      end
      p2 = p1; p2k = p1k; p1 = nv; p1k = nk;
      if (bus.iwrite) begin
        idx = wb * cBANK_B + int'(bus.iwaddr);
        if (cnt < cN) begin mm[idx] = bus.iwdat; mk[idx] = 1; end
        else mk[idx] = 0;
      end
      nl = wcnt + int'(bus.iwrite);
      if (nl > cBANK_B) nl = cBANK_B;
      if (iclr) begin
        rp = 0; cnt = 0; wcnt = 0; ovf = 0; udf = 0;
      end else begin
        cok = bus.iwfull && (cnt < cN);
        rok = bus.irempty && (cnt > 0);
        if (cok) begin tag_m[wb] = bus.iwtag; len_m[wb] = nl; end
        if (bus.iwfull && !cok) ovf = 1;
        if (bus.irempty && !rok) udf = 1;
        cnt = cnt + int'(cok) - int'(rok);
        if (rok) rp = (rp + 1) % cN;
        wcnt = bus.iwfull ? 0 : nl;
      end
    end
    @(posedge iclk);
    #1;
    check_outputs();
  endtask

  initial begin
    for (int i = 0; i < cN*cBANK_B; i++) begin mm[i] = '0; mk[i] = 0; end
    ireset = 0; iclkena = 1; idle();
    bus.iwaddr = '0; bus.iwdat = '0; bus.iwtag = '0; bus.iraddr = '0;
    model_reset();

    // 1: reset state
    #12 ireset = 1;
    check("t1_ocount",  32'(bus.ocount),  32'd0);
    check("t1_oempty",  32'(bus.oempty),  32'd1);
    check("t1_oemptya", 32'(bus.oemptya), 32'd1);
    check("t1_ofull",   32'(bus.ofull),   32'd0);
    check("t1_ofulla",  32'(bus.ofulla),  32'd0);
    check("t1_ortag",   32'(bus.ortag),   32'd0);
    check("t1_orlen",   32'(bus.orlen),   32'd0);
    step();

    // 2: one full frame of bytes, close, read back wide words
    for (int a = 0; a < cBANK_B; a++) begin
      bus.iwrite = 1; bus.iwaddr = 6'(a); bus.iwdat = 8'(a); step();
    end
    bus.iwrite = 0; bus.iwfull = 1; bus.iwtag = 8'h5A; step();
    bus.iwfull = 0;
    check("t2_ocount", 32'(bus.ocount), 32'd1);
    check("t2_ortag",  32'(bus.ortag),  32'h5A);
    check("t2_orlen",  32'(bus.orlen),  32'd64);
    bus.iraddr = 4'd0;  step();
    bus.iraddr = 4'd15; step();
    check("t2_rd0",  bus.ordat, 32'h0302_0100);
    step();
    check("t2_rd15", bus.ordat, 32'h3F3E_3D3C);

    // 3: fill all banks, overflow, drain in order
    iclr = 1; step(); iclr = 0;
    for (int t = 1; t <= 4; t++) begin bus.iwfull = 1; bus.iwtag = 8'(t); step(); end
    check("t3_ofulla", 32'(bus.ofulla), 32'd1);
    check("t3_ocount", 32'(bus.ocount), 32'd4);
    bus.iwtag = 8'h99; step(); bus.iwfull = 0;
    check("t3_oovf",   32'(bus.oovf),   32'd1);
    check("t3_ocnt5",  32'(bus.ocount), 32'd4);
    for (int t = 1; t <= 4; t++) begin
      check("t3_order", 32'(bus.ortag), 32'(t));
      bus.irempty = 1; step();
    end
    bus.irempty = 0;
    check("t3_oemptya", 32'(bus.oemptya), 32'd1);

    // 4: simultaneous close and release at count 2
    iclr = 1; step(); iclr = 0;
    bus.iwfull = 1; bus.iwtag = 8'h11; step();
    bus.iwtag = 8'h22; step();
    bus.iwtag = 8'h33; bus.irempty = 1; step();
    bus.iwfull = 0; bus.irempty = 0;
    check("t4_ocount", 32'(bus.ocount), 32'd2);
    check("t4_ortag",  32'(bus.ortag),  32'h22);
    bus.irempty = 1; step();
    check("t4_newtag", 32'(bus.ortag),  32'h33);
    step(); bus.irempty = 0;

    // 5: underflow then flush
    bus.irempty = 1; step(); bus.irempty = 0;
    check("t5_oudf",   32'(bus.oudf),   32'd1);
    check("t5_ocount", 32'(bus.ocount), 32'd0);
    check("t5_ortag",  32'(bus.ortag),  32'h04);
    iclr = 1; step(); iclr = 0;
    check("t5_clr_udf", 32'(bus.oudf),  32'd0);
    check("t5_clr_cnt", 32'(bus.ocount), 32'd0);

    // 6: async reset mid-frame, then clock enable low with strobes active
    for (int f = 0; f < 3; f++) begin
      for (int w = 0; w < 8; w++) begin
        bus.iwrite = 1; bus.iwaddr = 6'($urandom_range(63)); bus.iwdat = 8'($urandom); step();
      end
      bus.iwrite = 0; bus.iwfull = 1; bus.iwtag = 8'(8'h70 + f); step(); bus.iwfull = 0;
    end
    check("t6_ocount3", 32'(bus.ocount), 32'd3);
    bus.iwrite = 1; bus.iwaddr = 6'd5; bus.iwdat = 8'hC3; step();
    #2 ireset = 0;
    #1 model_reset();
    check("t6_ocount", 32'(bus.ocount), 32'd0);
    check("t6_oempty", 32'(bus.oempty), 32'd1);
    check("t6_ortag",  32'(bus.ortag),  32'd0);
    check("t6_orlen",  32'(bus.orlen),  32'd0);
    check("t6_ordat",  bus.ordat,       32'd0);
    check_outputs();
    @(negedge iclk); ireset = 1; idle();
    bus.iwfull = 1; bus.iwtag = 8'hA1; step();
    bus.iwtag = 8'hA2; step();
    iclkena = 0; bus.iwrite = 1; bus.iwfull = 1; bus.irempty = 1; iclr = 1;
    repeat (5) step();
    check("t6_hold_cnt", 32'(bus.ocount), 32'd2);
    check("t6_hold_tag", 32'(bus.ortag),  32'hA1);
    iclkena = 1; idle();

    // Random traffic against the model
    for (int c = 0; c < 800; c++) begin
      iclkena      = ($urandom_range(7) != 0);
      bus.iwrite   = $urandom_range(1);
      bus.iwaddr   = 6'($urandom_range(63));
      bus.iwdat    = 8'($urandom);
      bus.iwfull   = ($urandom_range(7) == 0);
      bus.iwtag    = 8'($urandom);
      bus.irempty  = ($urandom_range(6) == 0);
      bus.iraddr   = 4'($urandom_range(15));
      iclr         = ($urandom_range(63) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
